// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: pattern modes, FSM states and per-mode reset values.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_SWEEP  = 2'd3
  } mode_e;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  // Wide return so any LED width up to 32 can truncate it at the call site.
  function automatic logic [31:0] mode_init(input mode_e m, input logic [31:0] static_pat);
    case (m)
      MODE_COUNT: mode_init = '0;
      MODE_SWEEP: mode_init = 32'd1;
      default:    mode_init = static_pat;
    endcase
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running 0..PRESCALE-1 counter producing the pattern step tick; freezable and clearable.
module led_prescaler
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("led_prescaler: PRESCALE must be >= 2");
  end

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST) && !hold;

  // clr wins over hold so a paused mode switch still restarts the step period.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Animated LED pattern generator; mode requests are deferred to the next step boundary
// (or applied at once while paused) so the LEDs never change mid-step.
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned       CLK_HZ         = 125000000,
  parameter int unsigned       STEP_HZ        = 4,
  parameter int unsigned       LED_W          = 4,
  parameter logic [LED_W-1:0]  STATIC_PATTERN = LED_W'(4'b1010)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mode_valid,
  input  logic [1:0]       mode,
  output logic             mode_ready,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             step_tick
);

  localparam int unsigned PRESCALE = CLK_HZ / STEP_HZ;

  logic [0:0]       state_q, state_d;
  mode_e            cur_mode_q, cur_mode_d;
  mode_e            pend_mode_q, pend_mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             step_tick_q;
  logic [LED_W-1:0] step_led;
  logic             step_dir;
  logic             tick;
  logic             clr;

  led_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .resetn(resetn),
    .clr   (clr),
    .hold  (pause),
    .tick  (tick)
  );

  assign mode_ready = (state_q == ST_RUN);
  assign led        = led_q;
  assign step_tick  = step_tick_q;

  // dir_q=1 moves the lit bit towards the MSB; it flips on reaching either end.
  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    case (cur_mode_q)
      MODE_BLINK: step_led = ~led_q;
      MODE_COUNT: step_led = led_q + LED_W'(1);
      MODE_SWEEP: begin
        if (dir_q) begin
          if (led_q[LED_W-1]) begin
            step_led = led_q >> 1;
            step_dir = 1'b0;
          end else begin
            step_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            step_led = led_q << 1;
            step_dir = 1'b1;
          end else begin
            step_led = led_q >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    pend_mode_d = pend_mode_q;
    led_d       = led_q;
    dir_d       = dir_q;
    clr         = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tick) begin
          led_d = step_led;
          dir_d = step_dir;
        end
        if (mode_valid) begin
          pend_mode_d = mode_e'(mode);
          state_d     = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (tick || pause) begin
          cur_mode_d = pend_mode_q;
          led_d      = LED_W'(mode_init(pend_mode_q, 32'(STATIC_PATTERN)));
          dir_d      = 1'b1;
          clr        = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // step_tick simply follows tick: a pause-driven switch never coincides with a tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      cur_mode_q  <= MODE_STATIC;
      pend_mode_q <= MODE_STATIC;
      led_q       <= STATIC_PATTERN;
      dir_q       <= 1'b1;
      step_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_mode_q  <= cur_mode_d;
      pend_mode_q <= pend_mode_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
      step_tick_q <= tick;
    end
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Drives the board's 4 fabric LEDs with a selectable animated pattern instead of a fixed value. Contains a prescaler that derives a slow step tick from the fabric clock, a mode register loaded through a valid/ready request port, and a small FSM that defers mode changes to the next step boundary so the LEDs never glitch mid-step. Sits directly under top; its led output goes straight to the LED pins.

Parameters:
CLK_HZ, 125000000, fabric clock frequency in Hz
STEP_HZ, 4, pattern step rate in Hz; PRESCALE = CLK_HZ/STEP_HZ, must be >= 2 (elaboration error otherwise)
LED_W, 4, number of LEDs
STATIC_PATTERN, 4'b1010, pattern for STATIC mode and reset value of led

Ports:
clk  input  1  fabric clock, all logic rising-edge
resetn  input  1  asynchronous, active-low reset
mode_valid  input  1  mode change request valid
mode  input  2  requested mode: 0 STATIC, 1 BLINK, 2 COUNT, 3 SWEEP
mode_ready  output  1  request accepted when mode_valid && mode_ready
pause  input  1  freezes prescaler and pattern while high
led  output  LED_W  LED drive, registered
step_tick  output  1  one-cycle pulse on each pattern step, registered

Behaviour:
- Reset (resetn low, async): cur_mode=STATIC, led=STATIC_PATTERN, prescaler=0, step_tick=0, FSM=RUN, mode_ready=1, pending request discarded.
- Prescaler: counts 0..PRESCALE-1 and wraps; internal tick=1 when count==PRESCALE-1 and pause=0. pause=1 holds count and suppresses tick. step_tick is the tick delayed 1 cycle, aligned with the led update.
- Step actions on tick (led updates on the same edge that raises step_tick):
  STATIC: led unchanged.
  BLINK: led <= ~led (alternates STATIC_PATTERN / ~STATIC_PATTERN).
  COUNT: led <= led+1, modulo 2^LED_W (4'b1111 -> 4'b0000).
  SWEEP: one-hot bounce 0001,0010,0100,1000,0100,0010,0001,0010...; direction flips at each end, endpoints not repeated.
- FSM states: RUN, PENDING.
  RUN: mode_ready=1. On accept, latch mode into pend_mode and go to PENDING on the next edge. A tick in the accept cycle still advances the current pattern.
  PENDING: mode_ready=0. On the next tick, or on the first cycle with pause=1, apply the change instead of stepping: cur_mode<=pend_mode, prescaler<=0, led loaded with the mode's initial value, then go to RUN. Initial values: STATIC/BLINK=STATIC_PATTERN, COUNT=0, SWEEP=0001 with direction up. step_tick pulses on a switch caused by a tick; a switch caused by pause does not pulse it.
- Requesting the current mode still reloads its initial value (restart).
- mode is sampled only on accept; mode_valid while mode_ready=0 is ignored. The requester must hold it.
- Reset mid-PENDING: returns to the reset state, and the request is lost.
- Latency: accept-to-new-pattern is at most PRESCALE+1 cycles when unpaused, and 2 cycles when paused.

Decomposition:
- Package led_pkg: mode encodings (MODE_STATIC=0, MODE_BLINK=1, MODE_COUNT=2, MODE_SWEEP=3), FSM state encodings, and an initial-value function per mode.
- Sub-module led_prescaler (params PRESCALE; ports clk, resetn, clr, hold, tick) holds the counter. The mode FSM and pattern datapath stay in led_sequencer.

Test Plan:
(All with CLK_HZ=8, STEP_HZ=2, so PRESCALE=4.)
1. Reset, no requests: led=1010, and step_tick pulses every 4 cycles while led stays 1010. Asserting resetn low mid-cycle immediately forces led=1010.
2. Request COUNT: mode_ready drops the cycle after accept. At the next tick led=0000. Subsequent ticks give 0001, 0010, and so on. After 16 steps led wraps from 1111 to 0000.
3. Request SWEEP, then let 8 ticks run: led follows 0001,0010,0100,1000,0100,0010,0001,0010 with no repeated endpoints.
4. Request BLINK in the same cycle as a tick while in COUNT at 0011: that tick gives 0100. The next tick gives 1010 (not 0101), and the following tick gives 0101.
5. In PENDING, assert pause: the switch applies the next cycle with no step_tick. While paused, led and prescaler stay frozen for 20 cycles. The first step_tick comes 4 cycles after pause deasserts.
6. Hold mode_valid high with a changed mode value while PENDING: no second accept occurs. mode_ready returns high after the switch, and the held value is accepted then.
